// File: rtl/alarm_ctrl_pkg.sv
// Shared state encodings and sizing helpers for the alarm controller.
package alarm_ctrl_pkg;

    localparam int STATE_W = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_EXIT  = 3'd1;
    localparam logic [2:0] ST_ARMED = 3'd2;
    localparam logic [2:0] ST_ENTRY = 3'd3;
    localparam logic [2:0] ST_ALARM = 3'd4;

    // Width that holds the larger of the two delays without wrapping.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// Sensor/control and status bundle between the sensor front-end and alarm_ctrl.
interface alarm_ctrl_if
    import alarm_ctrl_pkg::*;
#(
    parameter int N_ZONES = 4
) ();

    logic                 arm;
    logic                 disarm;
    logic [N_ZONES-1:0]   zone;
    logic [N_ZONES-1:0]   mask;
    logic [STATE_W-1:0]   state;
    logic                 armed;
    logic                 pending;
    logic                 alarm;
    logic                 arm_fail;
    logic [N_ZONES-1:0]   trip_zones;

    modport master (
        output arm, disarm, zone, mask,
        input  state, armed, pending, alarm, arm_fail, trip_zones
    );

    modport slave (
        input  arm, disarm, zone, mask,
        output state, armed, pending, alarm, arm_fail, trip_zones
    );

endinterface

// File: rtl/alarm_ctrl_dly_counter.sv
// Loadable down-counter shared by the exit and entry delays; holds at zero.
module dly_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          zero
);

    logic [CW-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (en && (count_q != '0))
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/alarm_ctrl.sv
// Armable N-zone alarm FSM with exit/entry delays and latched alarm.
// Optional trip-zone capture register enabled by ALARM_ZONE_LATCH_EN.
module alarm_ctrl
    import alarm_ctrl_pkg::*;
#(
    parameter int N_ZONES   = 4,
    parameter int EXIT_DLY  = 8,
    parameter int ENTRY_DLY = 8
) (
    input  logic        clk,
    input  logic        rst,
    alarm_ctrl_if.slave bus
);

    localparam int CW = cnt_width(EXIT_DLY, ENTRY_DLY);
    localparam logic [CW-1:0] EXIT_LOAD  = CW'(EXIT_DLY - 1);
    localparam logic [CW-1:0] ENTRY_LOAD = CW'(ENTRY_DLY - 1);

    logic [STATE_W-1:0] state_d, state_q;
    logic               arm_fail_d, arm_fail_q;
    logic               cnt_load, cnt_en, cnt_zero;
    logic [CW-1:0]      cnt_val;
    logic [N_ZONES-1:0] act;
    logic [N_ZONES-2:0] act_hi;
`ifdef ALARM_ZONE_LATCH_EN
    logic [N_ZONES-1:0] trip_d, trip_q;
`endif

    assign act    = bus.zone & ~bus.mask;
    assign act_hi = act[N_ZONES-1:1];

    dly_counter #(.CW(CW)) u_dly (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        arm_fail_d = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_en     = 1'b0;
`ifdef ALARM_ZONE_LATCH_EN
        trip_d     = trip_q;
`endif
        if (bus.disarm) begin
            // Loading zero clears any delay in progress.
            state_d  = ST_IDLE;
            cnt_load = 1'b1;
`ifdef ALARM_ZONE_LATCH_EN
            trip_d   = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.arm) begin
                        if (act == '0) begin
                            state_d  = ST_EXIT;
                            cnt_load = 1'b1;
                            cnt_val  = EXIT_LOAD;
                        end else begin
                            arm_fail_d = 1'b1;
                        end
                    end
                end
                ST_EXIT: begin
                    if (cnt_zero) state_d = ST_ARMED;
                    else          cnt_en  = 1'b1;
                end
                ST_ARMED: begin
                    if (|act_hi) begin
                        state_d = ST_ALARM;
`ifdef ALARM_ZONE_LATCH_EN
                        trip_d  = act;
`endif
                    end else if (act[0]) begin
                        state_d  = ST_ENTRY;
                        cnt_load = 1'b1;
                        cnt_val  = ENTRY_LOAD;
                    end
                end
                ST_ENTRY: begin
                    if (|act_hi) begin
                        state_d = ST_ALARM;
`ifdef ALARM_ZONE_LATCH_EN
                        trip_d  = act;
`endif
                    end else if (cnt_zero) begin
                        // Timeout: the door zone is blamed even if it has since released.
                        state_d = ST_ALARM;
`ifdef ALARM_ZONE_LATCH_EN
                        trip_d  = act | N_ZONES'(1);
`endif
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                ST_ALARM: ;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            arm_fail_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            arm_fail_q <= arm_fail_d;
        end
    end

`ifdef ALARM_ZONE_LATCH_EN
    always_ff @(posedge clk) begin
        if (rst) trip_q <= '0;
        else     trip_q <= trip_d;
    end
    assign bus.trip_zones = trip_q;
`else
    assign bus.trip_zones = '0;
`endif

    assign bus.state    = state_q;
    assign bus.armed    = (state_q == ST_ARMED) || (state_q == ST_ENTRY);
    assign bus.pending  = (state_q == ST_EXIT)  || (state_q == ST_ENTRY);
    assign bus.alarm    = (state_q == ST_ALARM);
    assign bus.arm_fail = arm_fail_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed + random bench for alarm_ctrl against a cycle-count reference model.
module tb_alarm_ctrl;

    localparam int NZ        = 4;
    localparam int EXIT_DLY  = 8;
    localparam int ENTRY_DLY = 8;
`ifdef ALARM_ZONE_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alarm_ctrl_if #(.N_ZONES(NZ)) bus ();

    alarm_ctrl #(
        .N_ZONES   (NZ),
        .EXIT_DLY  (EXIT_DLY),
        .ENTRY_DLY (ENTRY_DLY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase name + elapsed cycles in that phase.
    int          m_st = 0;
    int          m_el = 0;
    bit          m_af = 1'b0;
    logic [NZ-1:0] m_tz = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        logic [NZ-1:0] a;
        a = bus.zone & ~bus.mask;
        if (rst || bus.disarm) begin
            m_st = 0; m_el = 0; m_af = 1'b0; m_tz = '0;
        end else begin
            m_af = 1'b0;
            case (m_st)
                0: if (bus.arm) begin
                       if (a == '0) begin m_st = 1; m_el = 0; end
                       else m_af = 1'b1;
                   end
                1: begin
                       m_el++;
                       if (m_el == EXIT_DLY) begin m_st = 2; m_el = 0; end
                   end
                2: if ((a >> 1) != '0) begin m_st = 4; m_tz = a; end
                   else if (a[0]) begin m_st = 3; m_el = 0; end
                3: if ((a >> 1) != '0) begin m_st = 4; m_tz = a; end
                   else begin
                       m_el++;
                       if (m_el == ENTRY_DLY) begin m_st = 4; m_tz = a | NZ'(1); end
                   end
                default: ;
            endcase
        end
        if (!LATCH) m_tz = '0;
    endtask

    task automatic check_all();
        chk("state",    32'(bus.state),      32'(m_st));
        chk("armed",    32'(bus.armed),      32'(m_st == 2 || m_st == 3));
        chk("pending",  32'(bus.pending),    32'(m_st == 1 || m_st == 3));
        chk("alarm",    32'(bus.alarm),      32'(m_st == 4));
        chk("arm_fail", 32'(bus.arm_fail),   32'(m_af));
        chk("trip",     32'(bus.trip_zones), 32'(m_tz));
    endtask

    task automatic drive(input logic a, input logic d, input logic [NZ-1:0] z,
                         input logic [NZ-1:0] m, input logic r);
        bus.arm = a; bus.disarm = d; bus.zone = z; bus.mask = m; rst = r;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic arm_seq(output int pend_cnt);
        pend_cnt = 0;
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        pend_cnt += int'(bus.pending);
        for (int i = 0; i < EXIT_DLY; i++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b0);
            pend_cnt += int'(bus.pending);
        end
    endtask

    initial begin
        int pc;
        int seen;
        logic [NZ-1:0] z, m;
        bit a, d, r;

        bus.arm = 1'b0; bus.disarm = 1'b0; bus.zone = '0; bus.mask = '0;

        // 1: reset, then arm into exit delay and on to ARMED
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        chk("reset_state", 32'(bus.state), 32'd0);
        arm_seq(pc);
        chk("exit_len", 32'(pc), 32'(EXIT_DLY));
        chk("armed_state", 32'(bus.state), 32'd2);

        // 2: perimeter zone trips, alarm latches until disarm
        drive(1'b0, 1'b0, 4'b0100, '0, 1'b0);
        chk("trip_0100", 32'(bus.trip_zones), LATCH ? 32'h4 : 32'h0);
        chk("alarm_on", 32'(bus.alarm), 32'd1);
        repeat (3) drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        chk("alarm_hold", 32'(bus.state), 32'd4);
        drive(1'b0, 1'b1, '0, '0, 1'b0);
        chk("disarm_trip", 32'(bus.trip_zones), 32'd0);

        // 3a: door opens, disarm during the entry delay
        arm_seq(pc);
        seen = 0;
        drive(1'b0, 1'b0, 4'b0001, '0, 1'b0);
        chk("entry_state", 32'(bus.state), 32'd3);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b0);
            seen += int'(bus.alarm);
        end
        drive(1'b0, 1'b1, '0, '0, 1'b0);
        seen += int'(bus.alarm);
        chk("no_alarm_3a", 32'(seen), 32'd0);

        // 3b: entry delay runs out
        arm_seq(pc);
        drive(1'b0, 1'b0, 4'b0001, '0, 1'b0);
        for (int i = 0; i < ENTRY_DLY; i++) drive(1'b0, 1'b0, '0, '0, 1'b0);
        chk("entry_timeout", 32'(bus.alarm), 32'd1);
        chk("trip_0001", 32'(bus.trip_zones), LATCH ? 32'h1 : 32'h0);
        drive(1'b0, 1'b1, '0, '0, 1'b0);

        // 4: arm refused with open zone, accepted once bypassed
        drive(1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0);
        chk("arm_fail_pulse", 32'(bus.arm_fail), 32'd1);
        drive(1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0);
        chk("arm_fail_clear", 32'(bus.arm_fail), 32'd0);
        drive(1'b1, 1'b0, 4'b0010, 4'b0010, 1'b0);
        chk("masked_arm", 32'(bus.state), 32'd1);
        for (int i = 0; i < EXIT_DLY; i++) drive(1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0);

        // 5: disarm beats arm and trip
        drive(1'b1, 1'b1, 4'b1000, '0, 1'b0);
        chk("disarm_wins", 32'(bus.state), 32'd0);

        // 6: reset mid-exit and during alarm
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        repeat (2) drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        chk("rst_exit", 32'(bus.pending), 32'd0);
        arm_seq(pc);
        drive(1'b0, 1'b0, 4'b1000, '0, 1'b0);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        chk("rst_alarm", 32'(bus.alarm), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            a = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 24) == 0);
            r = ($urandom_range(0, 199) == 0);
            z = ($urandom_range(0, 5) == 0) ? NZ'($urandom) : '0;
            m = ($urandom_range(0, 3) == 0) ? NZ'($urandom) : '0;
            drive(a, d, z, m, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
